// File: rtl/camera_ray_gen_pkg.sv
// Shared point/vec3/ray payload types (Q12.12 in 24-bit fields) and vector helpers
// used by the primary-ray generator.
package camera_ray_gen_pkg;

  localparam int unsigned COORD_W   = 24;
  localparam int unsigned FRAC_BITS = 12;
  localparam int unsigned PIX_W     = 12;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } point;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } vec3;

  typedef struct packed {
    point orig;
    vec3  dir;
  } ray;

  typedef enum logic {
    RG_IDLE = 1'b0,
    RG_RUN  = 1'b1
  } ray_gen_state_t;

  // Component-wise add, two's-complement wrap at COORD_W bits
  function automatic vec3 vec3_add(input vec3 a, input vec3 b);
    vec3 r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    r.z = a.z + b.z;
    return r;
  endfunction

  // Displacement from b to a, two's-complement wrap at COORD_W bits
  function automatic vec3 vec3_sub(input point a, input point b);
    vec3 r;
    r.x = a.x - b.x;
    r.y = a.y - b.y;
    r.z = a.z - b.z;
    return r;
  endfunction

endpackage

// File: rtl/camera_ray_gen_pix_counter.sv
// Raster x/y pixel counters with registered last-pixel flag.
// row_wrap_c flags that the current pixel is the final column of its row.
import camera_ray_gen_pkg::*;

module camera_pix_counter #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [PIX_W-1:0] x,
  output logic [PIX_W-1:0] y,
  output logic             last,
  output logic             row_wrap_c
);

  logic [PIX_W-1:0] x_nxt;
  logic [PIX_W-1:0] y_nxt;

  assign row_wrap_c = (x == PIX_W'(H_RES - 1));

  // Next raster position
  always_comb begin
    x_nxt = x + PIX_W'(1);
    y_nxt = y;
    if (row_wrap_c) begin
      x_nxt = '0;
      y_nxt = y + PIX_W'(1);
    end
  end

  // Counter state; last is precomputed so it lines up with the pixel it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      last <= 1'b0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      last <= (H_RES == 1) && (V_RES == 1);
    end else if (advance) begin
      x    <= x_nxt;
      y    <= y_nxt;
      last <= (x_nxt == PIX_W'(H_RES - 1)) && (y_nxt == PIX_W'(V_RES - 1));
    end
  end

endmodule

// File: rtl/camera_ray_gen.sv
// Primary-ray generator: one ray per pixel in raster order, direction built
// incrementally from corner-origin plus du/dv steps.
// Optional stall counter port enabled by CAMERA_RAY_GEN_STALL_CNT_EN.
import camera_ray_gen_pkg::*;

module camera_ray_gen #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  point             cfg_origin,
  input  point             cfg_corner,
  input  vec3              cfg_du,
  input  vec3              cfg_dv,
  output logic             busy,
  output logic             done,
  output ray               ray_out,
  output logic [PIX_W-1:0] ray_pix_x,
  output logic [PIX_W-1:0] ray_pix_y,
  output logic             ray_last,
  output logic             ray_valid,
`ifdef CAMERA_RAY_GEN_STALL_CNT_EN
  output logic [31:0]      stall_cnt,
`endif
  input  logic             ray_ready
);

  ray_gen_state_t state;
  vec3            du_q;
  vec3            dv_q;
  vec3            row_base;
  logic           xfer;
  logic           start_ok;
  logic           row_wrap_c;

  assign xfer     = ray_valid & ray_ready;
  assign start_ok = start & (state == RG_IDLE);

  camera_pix_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_pix_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .advance    (xfer & ~ray_last),
    .x          (ray_pix_x),
    .y          (ray_pix_y),
    .last       (ray_last),
    .row_wrap_c (row_wrap_c)
  );

  // Frame FSM, config latches and direction accumulators; ray_out.dir is the live accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RG_IDLE;
      du_q      <= '0;
      dv_q      <= '0;
      row_base  <= '0;
      ray_out   <= '0;
      ray_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RG_IDLE: begin
          if (start) begin
            du_q         <= cfg_du;
            dv_q         <= cfg_dv;
            row_base     <= vec3_sub(cfg_corner, cfg_origin);
            ray_out.orig <= cfg_origin;
            ray_out.dir  <= vec3_sub(cfg_corner, cfg_origin);
            ray_valid    <= 1'b1;
            busy         <= 1'b1;
            state        <= RG_RUN;
          end
        end
        RG_RUN: begin
          if (xfer) begin
            if (ray_last) begin
              ray_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= RG_IDLE;
            end else if (row_wrap_c) begin
              row_base    <= vec3_add(row_base, dv_q);
              ray_out.dir <= vec3_add(row_base, dv_q);
            end else begin
              ray_out.dir <= vec3_add(ray_out.dir, du_q);
            end
          end
        end
        default: state <= RG_IDLE;
      endcase
    end
  end

`ifdef CAMERA_RAY_GEN_STALL_CNT_EN
  // Cycles spent holding a valid ray that downstream has not taken
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (ray_valid & ~ray_ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_camera_ray_gen.sv
// Scoreboard bench for camera_ray_gen on a 4x3 grid. Expected rays come from a
// direct corner - origin + x*du + y*dv model.
import camera_ray_gen_pkg::*;

module tb_camera_ray_gen;

  localparam int unsigned H = 4;
  localparam int unsigned V = 3;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1) << FRAC_BITS;

  typedef struct packed {
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
    logic             last;
    point             orig;
    vec3              dir;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  point             cfg_origin;
  point             cfg_corner;
  vec3              cfg_du;
  vec3              cfg_dv;
  logic             busy;
  logic             done;
  ray               ray_out;
  logic [PIX_W-1:0] ray_pix_x;
  logic [PIX_W-1:0] ray_pix_y;
  logic             ray_last;
  logic             ray_valid;
  logic             ray_ready;
`ifdef CAMERA_RAY_GEN_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               pop_cnt  = 0;
  int               tnum     = 0;
  bit               rand_mode = 1'b0;
  bit               expect_done = 1'b0;
  bit               held_v = 1'b0;
  logic [169:0]     held;

  camera_ray_gen #(
    .H_RES (H),
    .V_RES (V)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_origin (cfg_origin),
    .cfg_corner (cfg_corner),
    .cfg_du     (cfg_du),
    .cfg_dv     (cfg_dv),
    .busy       (busy),
    .done       (done),
    .ray_out    (ray_out),
    .ray_pix_x  (ray_pix_x),
    .ray_pix_y  (ray_pix_y),
    .ray_last   (ray_last),
    .ray_valid  (ray_valid),
`ifdef CAMERA_RAY_GEN_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .ray_ready  (ray_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [COORD_W-1:0] mcoord(input logic [COORD_W-1:0] o, input logic [COORD_W-1:0] c,
                                                input logic [COORD_W-1:0] du, input logic [COORD_W-1:0] dv,
                                                input int unsigned x, input int unsigned y);
    logic [31:0] t;
    t = {8'h0, c} - {8'h0, o} + x * {8'h0, du} + y * {8'h0, dv};
    return t[COORD_W-1:0];
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int unsigned y = 0; y < V; y++) begin
      for (int unsigned x = 0; x < H; x++) begin
        e.x     = PIX_W'(x);
        e.y     = PIX_W'(y);
        e.last  = (x == H - 1) && (y == V - 1);
        e.orig  = cfg_origin;
        e.dir.x = mcoord(cfg_origin.x, cfg_corner.x, cfg_du.x, cfg_dv.x, x, y);
        e.dir.y = mcoord(cfg_origin.y, cfg_corner.y, cfg_du.y, cfg_dv.y, x, y);
        e.dir.z = mcoord(cfg_origin.z, cfg_corner.z, cfg_du.z, cfg_dv.z, x, y);
        sb.push_back(e);
      end
    end
  endtask

  // Called just after a falling edge; pulses start for one cycle and checks first-ray latency
  task automatic start_frame();
    pop_cnt = 0;
    push_frame();
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("lat_valid", 192'(ray_valid), 192'(1));
    chk("lat_busy",  192'(busy), 192'(1));
    chk("lat_pix",   192'({ray_pix_x, ray_pix_y}), 192'(0));
  endtask

  task automatic wait_done(input int budget, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (done) found = 1'b1;
    end
    if (!found) chk("done_timeout", 192'(0), 192'(1));
  endtask

  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while (pop_cnt < target && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pop_cnt < target) chk("pop_timeout", 192'(pop_cnt), 192'(target));
  endtask

  // Random backpressure, applied just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) ray_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: scoreboard pops on transfer, stall stability, done pulse timing
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (expect_done || done) begin
        chk("done_pulse", 192'(done), 192'(expect_done));
        if (expect_done) chk("done_idle", 192'({busy, ray_valid}), 192'(0));
      end
      expect_done = 1'b0;
      if (held_v) chk("stall_hold", 192'({ray_valid, ray_out, ray_pix_x, ray_pix_y, ray_last}), 192'(held));
      held_v = ray_valid && !ray_ready;
      held   = {ray_valid, ray_out, ray_pix_x, ray_pix_y, ray_last};
      if (ray_valid && ray_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra_ray", 192'(0), 192'(1));
        end else begin
          e = sb.pop_front();
          chk("pix_x", 192'(ray_pix_x), 192'(e.x));
          chk("pix_y", 192'(ray_pix_y), 192'(e.y));
          chk("last",  192'(ray_last), 192'(e.last));
          chk("orig",  192'(ray_out.orig), 192'(e.orig));
          chk("dir",   192'(ray_out.dir), 192'(e.dir));
          if (tnum == 1 && e.x == 12'd1 && e.y == 12'd1)
            chk("dir_1_1", 192'(ray_out.dir), 192'({24'hFFF000, 24'hFFF800, 24'hFFF000}));
          if (tnum == 5 && e.x == 12'd1 && e.y == 12'd0)
            chk("dir_x_wrap", 192'(ray_out.dir.x), 192'(24'h800000));
          expect_done = e.last;
          pop_cnt++;
        end
      end
    end
  end

  initial begin
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    ray_ready  = 1'b1;
    cfg_origin = '0;
    cfg_corner = '{x: 24'hFFE000, y: 24'hFFE800, z: 24'hFFF000};
    cfg_du     = '{x: ONE, y: 24'h0, z: 24'h0};
    cfg_dv     = '{x: 24'h0, y: ONE, z: 24'h0};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 192'(ray_valid), 192'(0));
    chk("rst_busy",  192'(busy), 192'(0));
    chk("rst_done",  192'(done), 192'(0));
    chk("rst_last",  192'(ray_last), 192'(0));
    chk("rst_pix",   192'({ray_pix_x, ray_pix_y}), 192'(0));
    chk("rst_ray",   192'(ray_out), 192'(0));
`ifdef CAMERA_RAY_GEN_STALL_CNT_EN
    chk("rst_stall", 192'(stall_cnt), 192'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Full-rate frame: 12 consecutive rays, done right after the last
    tnum = 1;
    start_frame();
    wait_done(50, n);
    chk("t1_cycles", 192'(n), 192'(12));

    // Start in the done cycle, then random backpressure
    tnum = 2;
    rand_mode = 1'b1;
    start_frame();
    wait_done(400, n);
    rand_mode = 1'b0;
    ray_ready = 1'b1;
    @(negedge clk);
    #1;

    // Start and cfg change mid-frame must be ignored
    tnum = 3;
    start_frame();
    wait_pops(3);
    start  = 1'b1;
    cfg_du = '{x: 24'h002000, y: 24'h000800, z: 24'h000000};
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("t3_busy", 192'(busy), 192'(1));
    wait_done(50, n);
    cfg_du = '{x: ONE, y: 24'h0, z: 24'h0};
    @(negedge clk);
    #1;

    // Reset mid-frame: abort with no done pulse, then restart at (0,0)
    tnum = 4;
    start_frame();
    wait_pops(5);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    chk("t4_valid", 192'(ray_valid), 192'(0));
    chk("t4_busy",  192'(busy), 192'(0));
    chk("t4_done",  192'(done), 192'(0));
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("t4_no_done", 192'(done), 192'(0));
    end
    start_frame();
    wait_done(50, n);
    @(negedge clk);
    #1;

    // Coordinate wrap without saturation
    tnum = 5;
    cfg_corner.x = 24'h7FF000;
    start_frame();
    wait_done(50, n);
    cfg_corner.x = 24'hFFE000;
    @(negedge clk);
    #1;

`ifdef CAMERA_RAY_GEN_STALL_CNT_EN
    // Stall counter: seven held cycles, cleared by the next start
    tnum = 6;
    ray_ready = 1'b0;
    start_frame();
    repeat (7) @(negedge clk);
    #1;
    chk("t6_stall7", 192'(stall_cnt), 192'(7));
    ray_ready = 1'b1;
    wait_done(50, n);
    chk("t6_stall_keep", 192'(stall_cnt), 192'(7));
    @(negedge clk);
    #1;
    start_frame();
    chk("t6_stall_clr", 192'(stall_cnt), 192'(0));
    wait_done(50, n);
    @(negedge clk);
    #1;
`endif

    chk("sb_drained", 192'(sb.size()), 192'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
